// File: rtl/rom_loader.sv
// Accepts ROM download bytes from data_io, queues them, and replays each byte into
// every SDRAM toggle-handshake port whose region contains the byte address.
module rom_loader #(
  parameter int                          NUM_PORTS = 2,
  parameter int                          DEPTH     = 4,
  parameter logic [7:0]                  ROM_INDEX = 8'd0,
  parameter logic [25*NUM_PORTS-1:0]     BASE      = {25'h0C000, 25'h0},
  parameter logic [25*NUM_PORTS-1:0]     SIZE      = {25'h20000, 25'h0C000},
  parameter logic [5*NUM_PORTS-1:0]      SPLIT_BIT = {5'd14, 5'd0}
) (
  input  logic                     i_clk_sys,
  input  logic                     i_reset,
  input  logic                     i_ioctl_downl,
  input  logic [7:0]               i_ioctl_index,
  input  logic                     i_ioctl_wr,
  input  logic [24:0]              i_ioctl_addr,
  input  logic [7:0]               i_ioctl_dout,
  output logic [NUM_PORTS-1:0]     o_port_req,
  input  logic [NUM_PORTS-1:0]     i_port_ack,
  output logic [23*NUM_PORTS-1:0]  o_port_a,
  output logic [2*NUM_PORTS-1:0]   o_port_ds,
  output logic [16*NUM_PORTS-1:0]  o_port_d,
  output logic                     o_port_we,
  output logic                     o_rom_loaded,
  output logic                     o_core_reset,
  output logic                     o_overflow
);

  localparam int             AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;

  state_t                     r_state, w_state_next;
  logic [24:0]                r_fifo_addr [DEPTH];
  logic [7:0]                 r_fifo_data [DEPTH];
  logic [AW-1:0]              r_wr_ptr, r_rd_ptr;
  logic [AW:0]                r_count, w_count_next;
  logic                       r_wr_d, r_dl_seen;
  logic [NUM_PORTS-1:0]       r_port_req, r_issued;
  logic [23*NUM_PORTS-1:0]    r_port_a;
  logic [2*NUM_PORTS-1:0]     r_port_ds;
  logic [16*NUM_PORTS-1:0]    r_port_d;
  logic                       r_port_we, r_rom_loaded, r_core_reset, r_overflow;
  logic                       w_accept, w_push, w_pop, w_issue, w_full, w_empty;
  logic                       w_ovf, w_load_done, w_rom_dl;
  logic [24:0]                w_head_addr;
  logic [7:0]                 w_head_data;
  logic [NUM_PORTS-1:0]       w_hit;
  logic [NUM_PORTS-1:0][22:0] w_a;
  logic [NUM_PORTS-1:0][1:0]  w_ds;

  assign w_rom_dl    = i_ioctl_downl && (i_ioctl_index == ROM_INDEX);
  assign w_accept    = i_ioctl_wr && !r_wr_d && w_rom_dl;
  assign w_full      = (r_count == DEPTH_CNT);
  assign w_empty     = (r_count == {(AW+1){1'b0}});
  assign w_push      = w_accept && (!w_full || w_pop);
  assign w_ovf       = w_accept && w_full && !w_pop;
  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];
  assign w_load_done = r_dl_seen && !i_ioctl_downl && w_empty && (r_state == S_IDLE);

  // Per-port region decode of the FIFO head; range compare widened to avoid wrap.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_dec
    localparam logic [24:0] P_BASE = BASE[25*gi +: 25];
    localparam logic [24:0] P_SIZE = SIZE[25*gi +: 25];
    localparam int          P_N    = int'(SPLIT_BIT[5*gi +: 5]);
    logic [23:0] w_off;

    assign w_hit[gi] = ({1'b0, w_head_addr} >= {1'b0, P_BASE}) &&
                       ({1'b0, w_head_addr} <  ({1'b0, P_BASE} + {1'b0, P_SIZE}));
    assign w_off     = 24'(w_head_addr - P_BASE);

    if (P_N == 0) begin : g_lin
      assign w_a[gi]  = w_off[23:1];
      assign w_ds[gi] = {w_off[0], ~w_off[0]};
    end else begin : g_split
      logic [23:0] w_hi, w_lo;
      assign w_hi     = (w_off >> (P_N + 1)) << P_N;
      assign w_lo     = w_off & ((24'd1 << P_N) - 24'd1);
      assign w_a[gi]  = w_hi[22:0] | w_lo[22:0];
      assign w_ds[gi] = {~w_off[P_N], w_off[P_N]};
    end
  end

  // FIFO occupancy update
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + (AW+1)'(1'b1);
      2'b01:   w_count_next = r_count - (AW+1)'(1'b1);
      default: w_count_next = r_count;
    endcase
  end

  // Sequencer: a byte leaves the FIFO only once every port it was sent to has acked
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_issue      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_state_next = S_ISSUE;
        else          w_state_next = S_IDLE;
      end
      S_ISSUE: begin
        if (w_hit == {NUM_PORTS{1'b0}}) begin
          w_pop        = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_issue      = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (&(~r_issued | ~(i_port_ack ^ r_port_req))) begin
          w_pop        = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk_sys) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // FIFO storage; contents are don't-care while the occupancy count says empty
  always_ff @(posedge i_clk_sys) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= i_ioctl_addr;
      r_fifo_data[r_wr_ptr] <= i_ioctl_dout;
    end
  end

  // Pointers, port outputs and status flags
  always_ff @(posedge i_clk_sys) begin
    r_wr_d <= i_ioctl_wr;
    if (i_reset) begin
      r_wr_ptr     <= {AW{1'b0}};
      r_rd_ptr     <= {AW{1'b0}};
      r_count      <= {(AW+1){1'b0}};
      r_port_req   <= {NUM_PORTS{1'b0}};
      r_issued     <= {NUM_PORTS{1'b0}};
      r_port_a     <= {(23*NUM_PORTS){1'b0}};
      r_port_ds    <= {(2*NUM_PORTS){1'b0}};
      r_port_d     <= {(16*NUM_PORTS){1'b0}};
      r_port_we    <= 1'b0;
      r_rom_loaded <= 1'b0;
      r_core_reset <= 1'b1;
      r_overflow   <= 1'b0;
      r_dl_seen    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1'b1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1'b1);
      r_count <= w_count_next;
      if (w_ovf) r_overflow <= 1'b1;
      if (w_issue) r_issued <= w_hit;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_issue && w_hit[i]) begin
          r_port_a[23*i +: 23] <= w_a[i];
          r_port_ds[2*i +: 2]  <= w_ds[i];
          r_port_d[16*i +: 16] <= {w_head_data, w_head_data};
          r_port_req[i]        <= ~r_port_req[i];
        end
      end
      if (w_rom_dl)         r_dl_seen <= 1'b1;
      else if (w_load_done) r_dl_seen <= 1'b0;
      if (w_load_done) r_rom_loaded <= 1'b1;
      r_port_we    <= i_ioctl_downl || !w_empty;
      r_core_reset <= !r_rom_loaded || r_port_we;
    end
  end

  assign o_port_req   = r_port_req;
  assign o_port_a     = r_port_a;
  assign o_port_ds    = r_port_ds;
  assign o_port_d     = r_port_d;
  assign o_port_we    = r_port_we;
  assign o_rom_loaded = r_rom_loaded;
  assign o_core_reset = r_core_reset;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: a region/lane reference model predicts each port
// write, a monitor pops predictions on every request toggle, an ack responder answers.
module tb_rom_loader;

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } exp_t;

  localparam int unsigned BASE_M [2] = '{32'h0, 32'hC000};
  localparam int unsigned SIZE_M [2] = '{32'hC000, 32'h20000};
  localparam int unsigned SPLT_M [2] = '{32'd0, 32'd14};

  logic        clk = 1'b0;
  logic        reset, downl, wr;
  logic [7:0]  index, dout;
  logic [24:0] addr;
  logic [1:0]  req, ack;
  logic [45:0] pa;
  logic [3:0]  pds;
  logic [31:0] pd;
  logic        we, loaded, core_reset, overflow;

  int   tests = 0;
  int   fails = 0;
  int   ack_delay = 0;
  int   n_acks = 0;
  exp_t q0[$];
  exp_t q1[$];

  rom_loader dut (
    .i_clk_sys(clk), .i_reset(reset), .i_ioctl_downl(downl), .i_ioctl_index(index),
    .i_ioctl_wr(wr), .i_ioctl_addr(addr), .i_ioctl_dout(dout),
    .o_port_req(req), .i_port_ack(ack), .o_port_a(pa), .o_port_ds(pds), .o_port_d(pd),
    .o_port_we(we), .o_rom_loaded(loaded), .o_core_reset(core_reset), .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: which ports a byte lands in, and at which word/lane.
  function automatic void model_push(input logic [24:0] ad, input logic [7:0] dt);
    int unsigned off, pw, ea;
    logic [1:0]  eds;
    exp_t        e;
    for (int p = 0; p < 2; p++) begin
      if (ad >= BASE_M[p] && ad < BASE_M[p] + SIZE_M[p]) begin
        off = ad - BASE_M[p];
        if (SPLT_M[p] == 0) begin
          ea  = off / 2;
          eds = (off % 2 == 1) ? 2'b10 : 2'b01;
        end else begin
          pw  = 1 << SPLT_M[p];
          ea  = (off / (2 * pw)) * pw + off % pw;
          eds = ((off / pw) % 2 == 1) ? 2'b01 : 2'b10;
        end
        e.a  = 23'(ea);
        e.ds = eds;
        e.d  = {dt, dt};
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
  endfunction

  // Monitor: every request toggle must match the oldest prediction for that port
  initial begin
    logic [1:0] prev;
    exp_t       e, got;
    prev = 2'b00;
    forever begin
      @(negedge clk);
      #1;
      if (reset !== 1'b1) begin
        for (int p = 0; p < 2; p++) begin
          if (req[p] !== prev[p]) begin
            got = {pa[23*p +: 23], pds[2*p +: 2], pd[16*p +: 16]};
            tests++;
            if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
              fails++;
              $display("FAIL port%0d unexpected write: got a=%h ds=%b d=%h", p, got.a, got.ds, got.d);
            end else begin
              e = (p == 0) ? q0.pop_front() : q1.pop_front();
              if (got !== e) begin
                fails++;
                $display("FAIL port%0d write: got a=%h ds=%b d=%h, expected a=%h ds=%b d=%h",
                         p, got.a, got.ds, got.d, e.a, e.ds, e.d);
              end
            end
          end
        end
      end
      prev = req;
    end
  end

  // Ack responder with programmable delay
  initial begin
    int cnt [2];
    ack = 2'b00;
    cnt = '{0, 0};
    forever begin
      @(negedge clk);
      #1;
      if (reset === 1'b1) begin
        ack = 2'b00;
        cnt = '{0, 0};
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (req[p] !== ack[p]) begin
            if (cnt[p] >= ack_delay) begin
              ack[p] = req[p];
              cnt[p] = 0;
              n_acks++;
            end else begin
              cnt[p]++;
            end
          end else begin
            cnt[p] = 0;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic send(input logic [24:0] ad, input logic [7:0] dt, input logic [7:0] idx,
                      input int low_cycles, input bit expect_push);
    @(negedge clk);
    addr  = ad;
    dout  = dt;
    index = idx;
    wr    = 1'b1;
    if (expect_push) model_push(ad, dt);
    @(negedge clk);
    wr = 1'b0;
    repeat (low_cycles - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    downl = 1'b0;
    wr    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"}, req, 2'b00);
    check({tag, "_a"}, pa, 46'h0);
    check({tag, "_ds"}, pds, 4'h0);
    check({tag, "_d"}, pd, 32'h0);
    check({tag, "_we"}, we, 1'b0);
    check({tag, "_loaded"}, loaded, 1'b0);
    check({tag, "_core_reset"}, core_reset, 1'b1);
    check({tag, "_overflow"}, overflow, 1'b0);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && req === ack) begin
        done = 1'b1;
        break;
      end
    end
    repeat (6) @(negedge clk);
    check({tag, "_drained"}, done, 1'b1);
  endtask

  initial begin
    logic [24:0] ra;
    logic [24:0] edges [4];
    edges = '{25'h0BFFF, 25'h0C000, 25'h2BFFF, 25'h2C000};
    reset = 1'b1; downl = 1'b0; wr = 1'b0; index = 8'd0; addr = 25'h0; dout = 8'h0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);
    check("idle_core_reset", core_reset, 1'b1);

    // Linear port, immediate ack
    downl = 1'b1;
    ack_delay = 0;
    send(25'h0, 8'hAA, 8'd0, 6, 1'b1);
    send(25'h1, 8'h55, 8'd0, 6, 1'b1);
    wait_drain("linear", 100);
    check("linear_we", we, 1'b1);

    // Split port: two byte-wide halves merge into word 0
    send(25'h0C000, 8'h12, 8'd0, 6, 1'b1);
    send(25'h10000, 8'h34, 8'd0, 6, 1'b1);
    wait_drain("split", 100);

    // Unmapped address and foreign index produce no writes
    send(25'h1FFFFFF, 8'h77, 8'd0, 6, 1'b1);
    send(25'h00010, 8'h66, 8'd1, 6, 1'b0);
    repeat (10) @(negedge clk);
    check("unmapped_overflow", overflow, 1'b0);
    check("unmapped_req_idle", req ^ ack, 2'b00);

    // Backpressure: four queued in order, fifth dropped
    ack_delay = 20;
    for (int i = 0; i < 5; i++) begin
      ra = 25'($urandom_range(0, 32'hBFFF));
      if (i == 4) check("bp_no_overflow_yet", overflow, 1'b0);
      send(ra, 8'($urandom_range(0, 255)), 8'd0, 3, i < 4);
    end
    check("bp_overflow", overflow, 1'b1);
    wait_drain("bp", 300);

    do_reset();
    check_reset_vals("reset2");

    // Randomized traffic over both regions, their edges and unmapped space
    downl = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ack_delay = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0:       ra = 25'($urandom_range(0, 32'hBFFF));
        1:       ra = 25'($urandom_range(32'hC000, 32'h2BFFF));
        2:       ra = edges[$urandom_range(0, 3)];
        default: ra = 25'($urandom_range(32'h2C000, 32'h1FFFFFF));
      endcase
      send(ra, 8'($urandom_range(0, 255)), 8'd0, 10, 1'b1);
    end
    wait_drain("random", 200);
    check("random_overflow", overflow, 1'b0);
    check("random_loaded", loaded, 1'b0);

    // Completion: download ends with two bytes still queued
    do_reset();
    ack_delay = 6;
    n_acks = 0;
    downl = 1'b1;
    send(25'h100, 8'h11, 8'd0, 1, 1'b1);
    send(25'h101, 8'h22, 8'd0, 1, 1'b1);
    downl = 1'b0;
    check("done_loaded_early", loaded, 1'b0);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (loaded === 1'b1) break;
    end
    check("done_loaded", loaded, 1'b1);
    check("done_acks_before_loaded", n_acks, 2);
    check("done_core_reset_held", core_reset, 1'b1);
    @(negedge clk);
    check("done_core_reset_release", core_reset, 1'b0);
    check("done_we", we, 1'b0);

    // Reset while a write is outstanding
    ack_delay = 40;
    downl = 1'b1;
    send(25'h20, 8'h5A, 8'd0, 1, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req[0] !== ack[0]) break;
    end
    check("wait_entered", req[0] ^ ack[0], 1'b1);
    do_reset();
    check_reset_vals("reset_wait");
    repeat (30) @(negedge clk);
    check("post_reset_we", we, 1'b0);
    check("post_reset_req", req, 2'b00);
    check("q0_empty", q0.size(), 0);
    check("q1_empty", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
